// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the two-requester AXI read arbiter.
// Holds the controller state encoding and the fixed AR burst attributes.
// Every burst is an 8-beat, 64-bit WRAP burst.
package axi_read_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   localparam logic [7:0] AR_LEN        = 8'd7;   // 8 beats
   localparam logic [2:0] AR_SIZE       = 3'd3;   // 8 bytes per beat
   localparam logic [1:0] AR_BURST_WRAP = 2'd2;
   localparam logic       AR_LOCK       = 1'b0;
   localparam logic [3:0] AR_CACHE      = 4'd0;
   localparam logic [2:0] AR_PROT       = 3'd6;   // instruction, non-secure, unprivileged

   localparam logic [2:0] LAST_BEAT_IDX = 3'd7;

endpackage

// File: rtl/axi_read_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker.
// Ports:
//   req_i        [1:0]  request bits
//   last_grant_i        index of the requester served last
//   gnt_o        [1:0]  one-hot grant (zero when no request)
module rr_pick2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         // On a tie, serve whoever was not served last.
         2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read master port between an instruction
// fetch requester (0) and a data load requester (1). One burst at a time.
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   req_valid/req_ready     per-requester burst handshake (ready is one-hot)
//   req_addr0/req_addr1     burst byte address per requester
//   resp_valid/data/last/err  beat forwarding to the granted requester
//   proto_err               sticky: short burst or mismatching rid seen
//   m_axi_ar*/m_axi_r*      AXI read address / read data channels
module axi_read_arbiter
   import axi_read_arbiter_pkg::*;
#(
   parameter int ID_WIDTH   = 13,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            req_valid,
   input  logic [ADDR_WIDTH-1:0] req_addr0,
   input  logic [ADDR_WIDTH-1:0] req_addr1,
   output logic [1:0]            req_ready,
   output logic [1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_last,
   output logic                  resp_err,
   output logic                  proto_err,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arlock,
   output logic [3:0]            m_axi_arcache,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   state_e                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [ID_WIDTH-1:0]   arid_q, arid_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic [2:0]            beat_q, beat_d;
   logic                  perr_q, perr_d;

   logic [1:0]            pick;
   logic                  beat;

   rr_pick2 u_pick (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .gnt_o        (pick)
   );

   // Requests are only looked at in IDLE; anything else just waits.
   assign req_ready = (state_q == ST_IDLE) ? pick : 2'b00;

   assign beat       = (state_q == ST_DATA) && m_axi_rvalid;
   assign resp_valid = beat ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
   assign resp_data  = m_axi_rdata;
   assign resp_last  = beat && m_axi_rlast;
   assign resp_err   = beat && (m_axi_rresp != 2'b00);
   assign proto_err  = perr_q;

   assign m_axi_arid    = arid_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = AR_LEN;
   assign m_axi_arsize  = AR_SIZE;
   assign m_axi_arburst = AR_BURST_WRAP;
   assign m_axi_arlock  = AR_LOCK;
   assign m_axi_arcache = AR_CACHE;
   assign m_axi_arprot  = AR_PROT;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      araddr_d     = araddr_q;
      arid_d       = arid_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      beat_d       = beat_q;
      perr_d       = perr_q;

      case (state_q)
         ST_IDLE: begin
            if (pick != 2'b00) begin
               grant_d   = pick[1];
               araddr_d  = pick[1] ? req_addr1 : req_addr0;
               arid_d    = ID_WIDTH'(pick[1]);
               arvalid_d = 1'b1;
               beat_d    = 3'd0;
               state_d   = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (m_axi_rvalid) begin
               beat_d = beat_q + 3'd1;
               // The beat is still delivered to the granted requester.
               if (m_axi_rid != ID_WIDTH'(grant_q))
                  perr_d = 1'b1;
               if (m_axi_rlast) begin
                  // A short burst is flagged but still terminates normally.
                  if (beat_q != LAST_BEAT_IDX)
                     perr_d = 1'b1;
                  rready_d     = 1'b0;
                  last_grant_d = grant_q;
                  beat_d       = 3'd0;
                  state_d      = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         araddr_q     <= '0;
         arid_q       <= '0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         beat_q       <= 3'd0;
         perr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         araddr_q     <= araddr_d;
         arid_q       <= arid_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         beat_q       <= beat_d;
         perr_q       <= perr_d;
      end
   end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: a table of burst scenarios,
// a hand-written mid-burst reset sequence, then randomized bursts checked
// against a small arbitration/protocol model.
module tb_axi_read_arbiter;

   localparam int IDW = 13;
   localparam int AW  = 64;
   localparam int DW  = 64;

   logic           clk = 1'b0;
   logic           reset;
   logic [1:0]     req_valid;
   logic [AW-1:0]  req_addr0, req_addr1;
   logic [1:0]     req_ready, resp_valid;
   logic [DW-1:0]  resp_data;
   logic           resp_last, resp_err, proto_err;
   logic [IDW-1:0] arid;
   logic [AW-1:0]  araddr;
   logic [7:0]     arlen;
   logic [2:0]     arsize;
   logic [1:0]     arburst;
   logic           arlock;
   logic [3:0]     arcache;
   logic [2:0]     arprot;
   logic           arvalid, arready;
   logic [IDW-1:0] rid;
   logic [DW-1:0]  rdata;
   logic [1:0]     rresp;
   logic           rlast, rvalid, rready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_read_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .resp_last(resp_last), .resp_err(resp_err), .proto_err(proto_err),
      .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
      .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock),
      .m_axi_arcache(arcache), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid),
      .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata),
      .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
      .m_axi_rready(rready)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One complete burst, called at a negedge while the DUT is idle.
   task automatic do_burst(input logic [1:0] rv, input logic [63:0] a0, input logic [63:0] a1,
                           input int ar_dly, input int last_beat, input int err_beat,
                           input int bad_rid_beat, input bit late_other,
                           input int exp_win, input bit exp_perr);
      logic [1:0]  wv;
      logic [1:0]  other;
      logic [63:0] d;
      wv    = (exp_win == 1) ? 2'b10 : 2'b01;
      other = ~wv;
      req_valid = rv; req_addr0 = a0; req_addr1 = a1;
      #1;
      chk("grant", 64'(req_ready), 64'(wv));
      tick();
      req_valid = rv & other;
      #1;
      chk("arvalid_set", 64'(arvalid), 64'd1);
      chk("ready_busy_addr", 64'(req_ready), 64'd0);
      for (int i = 0; i < ar_dly; i++) begin
         tick();
         chk("arvalid_hold", 64'(arvalid), 64'd1);
      end
      chk("araddr", araddr, (exp_win == 1) ? a1 : a0);
      chk("arid", 64'(arid), 64'(exp_win));
      arready = 1'b1;
      tick();
      arready = 1'b0;
      #1;
      chk("arvalid_drop", 64'(arvalid), 64'd0);
      chk("rready_set", 64'(rready), 64'd1);
      if (late_other) req_valid = req_valid | other;
      for (int b = 1; b <= last_beat; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            rvalid = 1'b0;
            #1;
            chk("resp_idle_gap", 64'(resp_valid), 64'd0);
            tick();
         end
         d = {$urandom, $urandom};
         rvalid = 1'b1; rdata = d;
         rresp  = (b == err_beat) ? 2'd2 : 2'd0;
         rid    = (b == bad_rid_beat) ? IDW'(1 - exp_win) : IDW'(exp_win);
         rlast  = (b == last_beat);
         #1;
         chk("resp_valid", 64'(resp_valid), 64'(wv));
         chk("resp_data", resp_data, d);
         chk("resp_err", 64'(resp_err), 64'(b == err_beat));
         chk("resp_last", 64'(resp_last), 64'(b == last_beat));
         chk("ready_busy_data", 64'(req_ready), 64'd0);
         tick();
      end
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
      #1;
      chk("rready_end", 64'(rready), 64'd0);
      chk("resp_after", 64'(resp_valid), 64'd0);
      chk("proto_err", 64'(proto_err), 64'(exp_perr));
      // Back in IDLE: a still-pending single requester is granted right away.
      chk("next_ready", 64'(req_ready), 64'(req_valid));
   endtask

   typedef struct {
      logic [1:0]  rv;
      logic [63:0] a0, a1;
      int          ar_dly, last_beat, err_beat, bad_rid_beat;
      bit          late_other;
      int          exp_win;
      bit          exp_perr;
   } vec_t;

   vec_t vecs[9];

   int  mdl_lg;
   bit  mdl_perr;

   initial begin
      vecs[0] = '{2'b11, 64'h1000, 64'h2000, 2, 8, 0, 0, 1'b0, 0, 1'b0};
      vecs[1] = '{2'b10, 64'h0,    64'h2000, 0, 8, 0, 0, 1'b0, 1, 1'b0};
      vecs[2] = '{2'b01, 64'h1000, 64'h0,    2, 8, 0, 0, 1'b0, 0, 1'b0};
      vecs[3] = '{2'b01, 64'h3008, 64'h0,    1, 8, 0, 0, 1'b1, 0, 1'b0};
      vecs[4] = '{2'b10, 64'h0,    64'h4000, 0, 8, 3, 0, 1'b0, 1, 1'b0};
      vecs[5] = '{2'b11, 64'h5000, 64'h6000, 1, 8, 0, 0, 1'b0, 0, 1'b0};
      vecs[6] = '{2'b11, 64'h7000, 64'h8000, 0, 8, 0, 0, 1'b0, 1, 1'b0};
      vecs[7] = '{2'b01, 64'h9000, 64'h0,    0, 5, 0, 0, 1'b0, 0, 1'b1};
      vecs[8] = '{2'b10, 64'h0,    64'hA000, 3, 8, 0, 0, 1'b0, 1, 1'b1};

      reset = 1'b0; req_valid = 2'b00; req_addr0 = '0; req_addr1 = '0;
      arready = 1'b0; rid = '0; rdata = '0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_arvalid", 64'(arvalid), 64'd0);
      chk("rst_rready", 64'(rready), 64'd0);
      chk("rst_araddr", araddr, 64'd0);
      chk("rst_arid", 64'(arid), 64'd0);
      chk("rst_proto_err", 64'(proto_err), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("arlen", 64'(arlen), 64'd7);
      chk("arsize", 64'(arsize), 64'd3);
      chk("arburst", 64'(arburst), 64'd2);
      chk("arlock", 64'(arlock), 64'd0);
      chk("arcache", 64'(arcache), 64'd0);
      chk("arprot", 64'(arprot), 64'd6);
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i])
         do_burst(vecs[i].rv, vecs[i].a0, vecs[i].a1, vecs[i].ar_dly, vecs[i].last_beat,
                  vecs[i].err_beat, vecs[i].bad_rid_beat, vecs[i].late_other,
                  vecs[i].exp_win, vecs[i].exp_perr);
      req_valid = 2'b00;

      // Reset during beat 4 of a burst for requester 0.
      tick();
      req_valid = 2'b01; req_addr0 = 64'h5000;
      tick();
      req_valid = 2'b00; arready = 1'b1;
      tick();
      arready = 1'b0;
      for (int b = 1; b <= 3; b++) begin
         rvalid = 1'b1; rid = '0; rdata = 64'(b);
         tick();
      end
      rvalid = 1'b1; rdata = 64'h4;
      #1;
      chk("rst_mid_beat4", 64'(resp_valid), 64'd1);
      reset = 1'b0;
      #1;
      chk("rst_mid_arvalid", 64'(arvalid), 64'd0);
      chk("rst_mid_rready", 64'(rready), 64'd0);
      chk("rst_mid_resp", 64'(resp_valid), 64'd0);
      chk("rst_mid_perr", 64'(proto_err), 64'd0);
      tick();
      reset = 1'b1;
      for (int b = 5; b <= 8; b++) begin
         rvalid = 1'b1; rdata = 64'(b); rlast = (b == 8);
         #1;
         chk("post_rst_resp", 64'(resp_valid), 64'd0);
         chk("post_rst_rready", 64'(rready), 64'd0);
         tick();
      end
      rvalid = 1'b0; rlast = 1'b0;
      // last_grant is back at 1, so requester 0 wins the tie.
      req_valid = 2'b11;
      #1;
      chk("post_rst_tie", 64'(req_ready), 64'd1);

      // Mismatching rid on beat 2: forwarded anyway, proto_err set.
      do_burst(2'b01, 64'hB000, 64'h0, 1, 8, 0, 2, 1'b0, 0, 1'b1);
      req_valid = 2'b00;

      // Randomized bursts against the model.
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      mdl_lg = 1; mdl_perr = 1'b0;
      for (int n = 0; n < 30; n++) begin
         logic [1:0]  rv;
         logic [63:0] a0, a1;
         int          win, lb, eb, bb;
         bit          late;
         rv   = 2'($urandom_range(1, 3));
         a0   = {$urandom, $urandom};
         a1   = {$urandom, $urandom};
         lb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 8;
         eb   = int'($urandom_range(0, 8));
         bb   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : 0;
         late = 1'($urandom_range(0, 1));
         if (rv == 2'b01)      win = 0;
         else if (rv == 2'b10) win = 1;
         else                  win = 1 - mdl_lg;
         if (lb != 8 || (bb != 0 && bb <= lb)) mdl_perr = 1'b1;
         do_burst(rv, a0, a1, int'($urandom_range(0, 3)), lb, eb, bb, late, win, mdl_perr);
         mdl_lg = win;
      end
      req_valid = 2'b00;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
